// File: rtl/uart_tx.sv
// UART transmitter: serializes a latched parallel word LSB-first on the bit-rate clock.
// Frame is start(0), DATA_WIDTH data bits, optional parity, stop(1).
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            state_dbg
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    par_en_q;
    logic                    par_bit_q;

    assign state_dbg = state;
    assign shift_nxt = shift_q >> 1;

    // Handshake: Data_Valid is a request strobe with no ready; it is taken only in IDLE
    // (Busy=0) and is silently dropped otherwise. Outputs reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        shift_q   <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= (^P_DATA) ^ PAR_TYP;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    TX_OUT  <= shift_q[0];
                    Busy    <= 1'b1;
                end
                DATA: begin
                    Busy <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit_q;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        // Shift so the next bit is always at position 0.
                        bit_cnt <= bit_cnt + 1'b1;
                        shift_q <= shift_nxt;
                        TX_OUT  <= shift_nxt[0];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
                end
                STOP: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    TX_OUT  <= 1'b1;
                    Busy    <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle {TX_OUT, Busy} expectations queued at stimulus time,
// popped and compared on every falling edge.
module tb_uart_tx;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         TX_OUT;
    logic         Busy;
    logic [2:0]   state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        logic         pen;
        logic         ptyp;
        logic         exp_par;
    } vec_t;

    vec_t vecs[10];

    uart_tx #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got no end of test required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    always @(negedge clk) begin
        logic [1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== e) begin
                failures++;
                $display("FAIL line cycle=%0d got tx=%b busy=%b expected tx=%b busy=%b",
                         cyc, TX_OUT, Busy, e[1], e[0]);
            end
        end
    end

    // Driver tasks
    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(2'b10);
    endtask

    task automatic push_frame(input logic [W-1:0] d, input logic pen, input logic par);
        exp_q.push_back(2'b01);
        for (int i = 0; i < W; i++) exp_q.push_back({d[i], 1'b1});
        if (pen) exp_q.push_back({par, 1'b1});
        exp_q.push_back(2'b11);
    endtask

    task automatic send(input logic [W-1:0] d, input logic pen, input logic ptyp,
                        input logic par, input int n_idle);
        @(negedge clk);
        #1;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        push_frame(d, pen, par);
        push_idle(n_idle);
        @(negedge clk);
        #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s got pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_now(input string name, input logic [1:0] want);
        checks++;
        if ({TX_OUT, Busy} !== want) begin
            failures++;
            $display("FAIL %s got tx=%b busy=%b required tx=%b busy=%b",
                     name, TX_OUT, Busy, want[1], want[0]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Directed rows with hand-derived parity, then random rows.
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1};
        for (int i = 6; i < 10; i++) begin
            vecs[i].data    = W'($urandom_range(0, 255));
            vecs[i].pen     = 1'($urandom_range(0, 1));
            vecs[i].ptyp    = 1'($urandom_range(0, 1));
            vecs[i].exp_par = (($countones(vecs[i].data) % 2) == 1) ^ vecs[i].ptyp;
        end

        // Reset state, then idle line
        repeat (3) @(negedge clk);
        check_now("reset_outputs", 2'b10);
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got %0d required 0", state_dbg);
        end
        #1;
        rst_n = 1'b1;
        push_idle(5);
        wait_drain("idle");

        // Table-driven frames; trailing idle checks Busy drops after the stop bit
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].data, vecs[i].pen, vecs[i].ptyp, vecs[i].exp_par, 2);
            wait_drain("vec");
        end

        // Request mid-frame is ignored and changes nothing in flight
        send(8'h3C, 1'b0, 1'b0, 1'b0, 3);
        repeat (3) @(negedge clk);
        #1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        Data_Valid = 1'b1;
        @(negedge clk);
        #1;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        wait_drain("ignore_busy");

        // Data_Valid held: exactly one idle cycle between frames, second takes new data
        @(negedge clk);
        #1;
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0);
        push_idle(1);
        push_frame(8'h0F, 1'b0, 1'b0);
        push_idle(3);
        repeat (3) @(negedge clk);
        #1;
        P_DATA = 8'h0F;
        repeat (9) @(negedge clk);
        #1;
        Data_Valid = 1'b0;
        wait_drain("held_valid");

        // Async reset during data bit 3
        send(8'hC3, 1'b0, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_now("async_reset", 2'b10);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        push_idle(4);
        wait_drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
